bcd_scan_ctrl: RTL

//  Sequences one shared BCD->7-segment decoder across a multi-digit display.
//  - Converts a binary word to packed BCD by serial double-dabble (shift/add-3), one bit per clock.
//  - Double-buffers the result into a display register.
//  - Time-multiplexes the digits onto the decoder's 4-bit input with one-hot digit enables.
//  - Sits between the datapath that produces the binary value and the single decoder/display driver.

---
 rtl/bcd_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bcd_scan_ctrl.sv
// Serial double-dabble binary->BCD converter feeding a double-buffered display
// register, time-multiplexed onto one shared BCD->7-segment decoder.
module bcd_scan_ctrl #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            digit_bcd,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (DIGITS < (BIN_W + 2) / 3) begin : g_digits_chk
    $error("bcd_scan_ctrl: DIGITS too small to hold BIN_W-bit values");
  end
  if (SCAN_DIV < 1) begin : g_scan_div_chk
    $error("bcd_scan_ctrl: SCAN_DIV must be at least 1");
  end

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   count;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_scratch;
  logic [BIN_W-1:0]   step_shift;
  logic               last_step;
  logic [BCD_W-1:0]   bcd_next;

  logic [PRE_W-1:0]   prescaler;
  logic [IDX_W-1:0]   index;
  logic               pre_wrap;
  logic [IDX_W-1:0]   idx_next;
  logic [3:0]         nib_next;
  logic [DIGITS-1:0]  sel_next;
  logic               upper_zero;

  // One double-dabble step: add 3 to every nibble >= 5 (no inter-nibble carry),
  // then shift {scratch, shift_reg} left by one.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
    end
    step_scratch = BCD_W'({adj, shift_reg[BIN_W-1]});
    step_shift   = shift_reg << 1;
  end

  assign last_step = (state == CONV) && (count == CNT_W'(1));
  assign bcd_next  = last_step ? step_scratch : bcd_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            count     <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          scratch   <= step_scratch;
          shift_reg <= step_shift;
          count     <= count - CNT_W'(1);
          if (last_step) begin
            bcd_out <= step_scratch;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The scan path looks at the display value this edge will commit, so
  // digit_bcd always matches bcd_out[index] with no one-cycle lag.
  always_comb begin
    pre_wrap = (prescaler == PRE_W'(SCAN_DIV - 1));
    idx_next = index;
    if (pre_wrap) begin
      idx_next = (index == IDX_W'(DIGITS - 1)) ? '0 : index + IDX_W'(1);
    end

    nib_next   = 4'd0;
    sel_next   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_next[i*4 +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
      if (idx_next == IDX_W'(i)) begin
        nib_next    = bcd_next[i*4 +: 4];
        sel_next[i] = !(BLANK_LZ && (i != 0) && upper_zero);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
      digit_bcd <= 4'd0;
      digit_sel <= DIGITS'(1);
    end else begin
      prescaler <= pre_wrap ? '0 : prescaler + PRE_W'(1);
      index     <= idx_next;
      digit_bcd <= nib_next;
      digit_sel <= sel_next;
    end
  end

endmodule
